pll_supervisor: RTL and testbench



---
 rtl/pll_supervisor_pkg.sv | 25 ++
 rtl/pll_supervisor_sync_2ff.sv | 23 ++
 rtl/pll_supervisor.sv | 133 +++++++++++++
 tb/tb_pll_supervisor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pll_supervisor_pkg.sv
// Shared state encoding and default timing constants for the PLL supervisor.
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        LOSS,
        FAIL
    } state_t;

    localparam int DEF_NUM_PLL             = 5;
    localparam int DEF_RST_PULSE_CYCLES    = 270;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 2700000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 27000;
    localparam int DEF_MAX_RETRIES         = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_supervisor_sync_2ff.sv
// Generic two-flop synchronizer; both stages reset to 0 asynchronously.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_supervisor.sv
// PLL bank supervisor: pulses PLL reset, qualifies lock, releases system reset.
// Define PLL_SUPERVISOR_LOSS_CNT_EN to build the saturating lock-loss counter.
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int NUM_PLL             = DEF_NUM_PLL,
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                             clk_27m,
    input  logic                             reset,
    input  logic [NUM_PLL-1:0]               pll_lock,
    output logic                             pll_reset,
    output logic                             sys_reset,
    output logic                             all_locked,
    output logic                             pll_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [7:0]                       loss_cnt
);

    localparam int CNT_W = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                       LOCK_STABLE_CYCLES) + 1);
    localparam int RC_W  = $clog2(MAX_RETRIES + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_PLL-1:0] lock_sync;

    sync_2ff #(.WIDTH(NUM_PLL)) u_sync (
        .clk   (clk_27m),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_sync)
    );

    always_ff @(posedge clk_27m or posedge reset) begin
        if (reset) all_locked <= 1'b0;
        else       all_locked <= &lock_sync;
    end

    always_ff @(posedge clk_27m or posedge reset) begin
        if (reset) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            pll_fail  <= 1'b0;
            retry_cnt <= '0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == CNT_W'(RST_PULSE_CYCLES - 1)) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (all_locked) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        if (retry_cnt == RC_W'(MAX_RETRIES - 1)) begin
                            state    <= FAIL;
                            pll_fail <= 1'b1;
                        end else begin
                            state     <= PLL_RST;
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    // The WAIT_LOCK cycle that saw the lock is the first locked cycle,
                    // so the window closes one count early to land exactly on N cycles.
                    if (!all_locked) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 2)) begin
                        state     <= RUN;
                        cnt       <= '0;
                        sys_reset <= 1'b0;
                        retry_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!all_locked) begin
                        state     <= LOSS;
                        cnt       <= '0;
                        sys_reset <= 1'b1;
                    end
                end
                LOSS: begin
                    state     <= PLL_RST;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                end
                FAIL: begin
                    pll_reset <= 1'b1;
                    sys_reset <= 1'b1;
                    pll_fail  <= 1'b1;
                end
                default: begin
                    state     <= PLL_RST;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    sys_reset <= 1'b1;
                end
            endcase
        end
    end

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    always_ff @(posedge clk_27m or posedge reset) begin
        if (reset)
            loss_cnt <= 8'd0;
        else if (state == RUN && !all_locked && loss_cnt != 8'hFF)
            loss_cnt <= loss_cnt + 8'd1;
    end
`else
    assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench: stimulus queues expected output edges and level snapshots by cycle.
module tb_pll_supervisor;

    localparam int END_CYC = 245;
    localparam int PR = 0, SR = 1, AL = 2, PF = 3, RC = 4, LC = 5;
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    localparam int LC_EN = 1;
`else
    localparam int LC_EN = 0;
`endif

    logic       clk_27m = 1'b0;
    logic       reset   = 1'b1;
    logic [4:0] pll_lock = 5'h00;
    logic       pll_reset, sys_reset, all_locked, pll_fail;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    pll_supervisor #(
        .NUM_PLL             (5),
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (3)
    ) dut (
        .clk_27m    (clk_27m),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .sys_reset  (sys_reset),
        .all_locked (all_locked),
        .pll_fail   (pll_fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 clk_27m = ~clk_27m;

    int cyc = 0;
    always @(posedge clk_27m) cyc <= cyc + 1;

    typedef struct {int sig; int val; int cyc;} ev_t;
    typedef struct {int cyc; int v[6];} lvl_t;
    ev_t  evq[$];
    lvl_t lvq[$];
    int   checks = 0;
    int   failures = 0;

    function automatic string nm(input int s);
        case (s)
            PR: return "pll_reset";
            SR: return "sys_reset";
            AL: return "all_locked";
            PF: return "pll_fail";
            RC: return "retry_cnt";
            default: return "loss_cnt";
        endcase
    endfunction

    task automatic ex(input int s, input int v, input int c);
        ev_t e;
        e.sig = s; e.val = v; e.cyc = c;
        evq.push_back(e);
    endtask

    task automatic lv(input int c, input int pr, input int sr, input int al,
                      input int pf, input int rc, input int lc);
        lvl_t l;
        l.cyc = c;
        l.v[PR] = pr; l.v[SR] = sr; l.v[AL] = al;
        l.v[PF] = pf; l.v[RC] = rc; l.v[LC] = lc;
        lvq.push_back(l);
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk_27m);
            #1;
        end
    endtask

    // Monitor: every output change must consume a matching queued edge.
    int   prev[6] = '{1, 1, 0, 0, 0, 0};
    int   obs[6];
    int   idx;
    lvl_t cur;
    always @(negedge clk_27m) begin
        obs[PR] = int'(pll_reset);
        obs[SR] = int'(sys_reset);
        obs[AL] = int'(all_locked);
        obs[PF] = int'(pll_fail);
        obs[RC] = int'(retry_cnt);
        obs[LC] = int'(loss_cnt);
        for (int s = 0; s < 6; s++) begin
            if (obs[s] != prev[s]) begin
                idx = -1;
                for (int i = 0; i < evq.size(); i++) begin
                    if (evq[i].sig == s) begin
                        idx = i;
                        break;
                    end
                end
                checks++;
                if (idx < 0) begin
                    failures++;
                    $display("FAIL edge %s: got change to %0d at cycle %0d, required no change",
                             nm(s), obs[s], cyc);
                end else begin
                    if (evq[idx].val != obs[s] || evq[idx].cyc != cyc) begin
                        failures++;
                        $display("FAIL edge %s: got %0d at cycle %0d, required %0d at cycle %0d",
                                 nm(s), obs[s], cyc, evq[idx].val, evq[idx].cyc);
                    end
                    evq.delete(idx);
                end
                prev[s] = obs[s];
            end
        end
        while (lvq.size() > 0 && lvq[0].cyc <= cyc) begin
            cur = lvq.pop_front();
            for (int s = 0; s < 6; s++) begin
                checks++;
                if (obs[s] != cur.v[s]) begin
                    failures++;
                    $display("FAIL level %s at cycle %0d: got %0d, required %0d",
                             nm(s), cyc, obs[s], cur.v[s]);
                end
            end
        end
        if (cyc == END_CYC) begin
            checks++;
            if (evq.size() != 0) begin
                failures++;
                foreach (evq[i])
                    $display("FAIL missing edge %s: got none, required %0d at cycle %0d",
                             nm(evq[i].sig), evq[i].val, evq[i].cyc);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        // Reset state
        lv(1, 1, 1, 0, 0, 0, 0);

        // Normal bring-up: 4-cycle PLL reset, sys_reset falls 8 cycles after lock
        at(2);   reset = 1'b0;
        ex(PR, 0, 6);
        at(8);   pll_lock = 5'h1F;
        ex(AL, 1, 11); ex(SR, 0, 19);

        // Loss in RUN, then partial lock times out once
        at(25);  pll_lock = 5'h1E;
        ex(AL, 0, 28); ex(SR, 1, 29);
        if (LC_EN != 0) ex(LC, 1, 29);
        ex(PR, 1, 30); ex(PR, 0, 34);
        lv(31, 1, 1, 0, 0, 0, LC_EN);
        ex(RC, 1, 54); ex(PR, 1, 54); ex(PR, 0, 58);
        lv(56, 1, 1, 0, 0, 1, LC_EN);

        // Stability window: 1-cycle dropout of bit 2 at cnt = 5
        at(60);  pll_lock = 5'h1F;
        ex(AL, 1, 63);
        at(66);  pll_lock = 5'h1B;
        ex(AL, 0, 69); ex(AL, 1, 70); ex(SR, 0, 78); ex(RC, 0, 78);
        at(67);  pll_lock = 5'h1F;

        // Failure: lose all locks, three timeouts
        at(80);  pll_lock = 5'h00;
        ex(AL, 0, 83); ex(SR, 1, 84);
        if (LC_EN != 0) ex(LC, 2, 84);
        ex(PR, 1, 85);  ex(PR, 0, 89);
        ex(RC, 1, 109); ex(PR, 1, 109); ex(PR, 0, 113);
        ex(RC, 2, 133); ex(PR, 1, 133); ex(PR, 0, 137);
        ex(PR, 1, 157); ex(PF, 1, 157);
        lv(165, 1, 1, 0, 1, 2, 2 * LC_EN);

        // Reset clears the sticky failure
        at(170); reset = 1'b1;
        ex(PF, 0, 170); ex(RC, 0, 170);
        if (LC_EN != 0) ex(LC, 0, 170);
        lv(170, 1, 1, 0, 0, 0, 0);
        at(172); reset = 1'b0;
        ex(PR, 0, 176);
        ex(RC, 1, 196); ex(PR, 1, 196); ex(PR, 0, 200);
        ex(RC, 2, 220); ex(PR, 1, 220); ex(PR, 0, 224);
        lv(228, 0, 1, 0, 0, 2, 0);

        // Async reset mid-WAIT_LOCK with retry_cnt = 2
        at(230); reset = 1'b1;
        ex(PR, 1, 230); ex(RC, 0, 230);
        lv(230, 1, 1, 0, 0, 0, 0);
        at(233); reset = 1'b0;
        ex(PR, 0, 237);
    end

endmodule
